mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory port of the multi-cycle core between two
//  requesters: port 0 is the MIPS core (fetch/load/store), port 1 is the program loader/debug master.
//  Round-robin arbitration, one transaction outstanding, fixed memory read latency.
//  Sits between the requesters and the memory. Requesters hold their request until it is granted.
// PARAMETERS
//  WIDTH   32  data width of mem_wd/mem_rd/wd*/rdata
//  AW      32  address width of adr*/mem_adr
//  RD_LAT  1   memory cycles from mem_adr valid to mem_rd valid; legal range 1..15
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-low reset (0 = reset)
//  req0      in   1      core request; hold with we0/adr0/wd0 stable until gnt0 sampled high
//  we0       in   1      core: 1 = write, 0 = read
//  adr0      in   AW     core address
//  wd0       in   WIDTH  core write data
//  gnt0      out  1      core request accepted this cycle (1-cycle pulse)
//  rvalid0   out  1      rdata holds core read result (1-cycle pulse)
//  req1/we1/adr1/wd1/gnt1/rvalid1   same as port 0, for the loader
//  rdata     out  WIDTH  read result, shared; qualified by rvalid0/rvalid1
//  mem_we    out  1      memory write enable
//  mem_adr   out  AW     memory address
//  mem_wd    out  WIDTH  memory write data
//  mem_rd    in   WIDTH  memory read data, valid RD_LAT cycles after mem_adr presented
//  busy      out  1      1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, last=1 (port 0 wins first tie), cnt=0, owner=0,
//   captured adr/wd/we=0, rdata=0; gnt*, rvalid*, mem_we, busy=0; mem_adr=0, mem_wd=0.
//  Reset mid-transaction: in-flight access dropped, no rvalid issued, no further mem_we.
//  States: IDLE, WRITE, READ, RESP.
//  IDLE: winner = only requester, or if both request, the port != last.
//   gnt[winner] high combinationally in that cycle; never both gnts high.
//   At the edge: capture adr/we/wd of winner, owner<=winner, last<=winner;
//   we=1 -> WRITE; we=0 -> READ with cnt<=RD_LAT-1. No request: stay IDLE.
//  WRITE: mem_we=1 for exactly this one cycle with captured mem_adr/mem_wd; -> IDLE.
//  READ: mem_adr=captured address, mem_we=0; cnt decrements each cycle;
//   when cnt==0: rdata<=mem_rd, -> RESP.
//  RESP: rvalid[owner]=1 for one cycle, rdata stable; -> IDLE.
//   rdata holds its value until the next read completes.
//  mem_adr/mem_wd hold the captured values outside WRITE/READ (no spurious toggling); mem_we=0.
//  Latency: write = 2 cycles accept-to-idle; read = rvalid RD_LAT+1 cycles after the gnt cycle.
//   Next gnt is possible in the cycle after RESP (IDLE).
//  gnt is only given in IDLE; requests arriving while busy wait, stable, in IDLE.
//  Fairness: with both requesting continuously, grants alternate 0,1,0,1,...
//   A lone requester is granted back-to-back regardless of last.
//  Address/data forwarded unmodified; no alignment check (core guarantees word alignment).
//  No simultaneous-grant, no pipelining: exactly one transaction owns the memory at a time.
// TESTING
//  1 Assert reset=0 mid-READ, RD_LAT=3 -> all outputs 0 immediately, no rvalid; after release,
//    first tie goes to port 0.
//  2 RD_LAT=2, req0 read adr0=0x40, mem[0x40]=0xDEADBEEF -> gnt0 at t0,
//    mem_adr=0x40 t1..t2, rvalid0 with rdata=0xDEADBEEF at t3 only.
//  3 req1 write adr1=0x10, wd1=0x1234 -> gnt1 at t0, mem_we=1 at t1 only with
//    mem_adr=0x10, mem_wd=0x1234; busy=0 at t2; no rvalid.
//  4 req0 and req1 both held high for 4 reads -> grant order 0,1,0,1;
//    each rvalid on its owner port only; gnt0&gnt1 never both 1.
//  5 req0 only, continuous reads, RD_LAT=1 -> gnt0 every 3 cycles, last ignored;
//    rdata matches each address.
//  6 req1 raised while port 0 in READ -> gnt1 in first IDLE cycle after RESP;
//    adr1 change before gnt is not observed on mem_adr.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single unified instruction/data memory port between the MIPS core
//   (port 0) and the program loader / debug master (port 1). Round-robin between
//   the two ports, one transaction at a time, fixed memory read latency RD_LAT.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | accepting; grants the winning requester combinationally
//   WRITE  | single-cycle memory write with the captured address/data
//   READ   | address held on the memory port while cnt counts down
//   RESP   | rdata valid, rvalid pulsed on the owning port
//
// Ports
//   clk, reset                 clock, async active-low reset (0 = reset)
//   req*/we*/adr*/wd*          requester inputs, held until gnt* is seen high
//   gnt*                       request accepted this cycle (IDLE only)
//   rvalid*                    rdata carries this port's read result
//   rdata                      shared read result, held until the next read
//   mem_we/mem_adr/mem_wd      memory command; adr/wd hold between accesses
//   mem_rd                     memory read data, RD_LAT cycles after mem_adr
//   busy                       transaction in progress (state != IDLE)
module mem_arbiter #(
  parameter int WIDTH  = 32,
  parameter int AW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    adr0,
  input  logic [WIDTH-1:0] wd0,
  output logic             gnt0,
  output logic             rvalid0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    adr1,
  input  logic [WIDTH-1:0] wd1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_we,
  output logic [AW-1:0]    mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic any_req;
  logic win;

  // Winner selection: a lone requester always wins; on a tie the port that
  // was not served last wins.
  always_comb begin
    any_req = req0 | req1;
    win     = 1'b0;
    if (req0 && req1) begin
      win = ~last_q;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = win;
          last_d  = win;
          adr_d   = win ? adr1 : adr0;
          wd_d    = win ? wd1  : wd0;
          we_d    = win ? we1  : we0;
          if (win ? we1 : we0) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ: begin
        if (cnt_q == 4'd0) begin
          rdata_d = mem_rd;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grants are masked while reset is asserted so every output reads 0 then.
  always_comb begin
    gnt0    = reset && (state_q == S_IDLE) && any_req && !win;
    gnt1    = reset && (state_q == S_IDLE) && any_req && win;
    rvalid0 = (state_q == S_RESP) && !owner_q;
    rvalid1 = (state_q == S_RESP) && owner_q;
    mem_we  = (state_q == S_WRITE) && we_q;
    busy    = (state_q != S_IDLE);
    mem_adr = adr_q;
    mem_wd  = wd_q;
    rdata   = rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Three instances (RD_LAT = 1, 2, 3) share the
// requester inputs; each directed step checks the instance with the latency it
// is about. Memory content is a fixed function of the address.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] adr0, wd0, adr1, wd1;

  logic [2:0]  gnt0_v, gnt1_v, rvalid0_v, rvalid1_v, mem_we_v, busy_v;
  logic [31:0] rdata_v   [3];
  logic [31:0] mem_adr_v [3];
  logic [31:0] mem_wd_v  [3];
  logic [31:0] mem_rd_v  [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign mem_rd_v[g] = memf(mem_adr_v[g]);
    mem_arbiter #(.WIDTH(32), .AW(32), .RD_LAT(g + 1)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .req0   (req0),
      .we0    (we0),
      .adr0   (adr0),
      .wd0    (wd0),
      .gnt0   (gnt0_v[g]),
      .rvalid0(rvalid0_v[g]),
      .req1   (req1),
      .we1    (we1),
      .adr1   (adr1),
      .wd1    (wd1),
      .gnt1   (gnt1_v[g]),
      .rvalid1(rvalid1_v[g]),
      .rdata  (rdata_v[g]),
      .mem_we (mem_we_v[g]),
      .mem_adr(mem_adr_v[g]),
      .mem_wd (mem_wd_v[g]),
      .mem_rd (mem_rd_v[g]),
      .busy   (busy_v[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset two cycles, check every instance is cleared, release mid-cycle.
  task automatic do_reset();
    reset = 1'b0;
    req0 = 1'b0; we0 = 1'b0; adr0 = '0; wd0 = '0;
    req1 = 1'b0; we1 = 1'b0; adr1 = '0; wd1 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_busy",   busy_v[g],    0);
      chk("rst_mem_we", mem_we_v[g],  0);
      chk("rst_rvalid", {rvalid1_v[g], rvalid0_v[g]}, 0);
      chk("rst_mem_adr", mem_adr_v[g], 0);
      chk("rst_rdata",  rdata_v[g],   0);
    end
    reset = 1'b1;
  endtask

  // Two grants in the same cycle must never happen on any instance.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int g = 0; g < 3; g++) begin
        tests++;
        assert (!(gnt0_v[g] && gnt1_v[g]))
        else begin
          fails++;
          $error("FAIL dual_gnt inst %0d: observed 1 expected 0", g);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          exp_port;

    // ---- reset mid-READ, RD_LAT=3 (instance 2) ----
    do_reset();
    tick();
    req0 = 1'b1; we0 = 1'b0; adr0 = 32'h80;
    #1;
    chk("t1_gnt0", gnt0_v[2], 1);
    tick();
    req0 = 1'b0;
    #1;
    chk("t1_busy_read", busy_v[2], 1);
    chk("t1_mem_adr", mem_adr_v[2], 32'h80);
    tick();
    reset = 1'b0;
    req0  = 1'b1;
    #1;
    chk("t1_rst_busy",    busy_v[2],    0);
    chk("t1_rst_mem_adr", mem_adr_v[2], 0);
    chk("t1_rst_mem_we",  mem_we_v[2],  0);
    chk("t1_rst_gnt0",    gnt0_v[2],    0);
    chk("t1_rst_rdata",   rdata_v[2],   0);
    tick();
    chk("t1_rst_rvalid", {rvalid1_v[2], rvalid0_v[2]}, 0);
    tick();
    chk("t1_rst_rvalid2", {rvalid1_v[2], rvalid0_v[2]}, 0);
    reset = 1'b1;
    req1  = 1'b1; we1 = 1'b0; adr1 = 32'h84;
    #1;
    chk("t1_tie_gnt0", gnt0_v[2], 1);
    chk("t1_tie_gnt1", gnt1_v[2], 0);

    // ---- single read, RD_LAT=2 (instance 1) ----
    do_reset();
    tick();
    req0 = 1'b1; we0 = 1'b0; adr0 = 32'h40;
    #1;
    chk("t2_gnt0_t0", gnt0_v[1], 1);
    chk("t2_gnt1_t0", gnt1_v[1], 0);
    tick();
    req0 = 1'b0;
    #1;
    chk("t2_adr_t1",    mem_adr_v[1], 32'h40);
    chk("t2_we_t1",     mem_we_v[1],  0);
    chk("t2_rvalid_t1", rvalid0_v[1], 0);
    tick();
    chk("t2_adr_t2",    mem_adr_v[1], 32'h40);
    chk("t2_rvalid_t2", rvalid0_v[1], 0);
    tick();
    chk("t2_rvalid0_t3", rvalid0_v[1], 1);
    chk("t2_rvalid1_t3", rvalid1_v[1], 0);
    chk("t2_rdata_t3",   rdata_v[1],   32'hDEAD_BEEF);
    tick();
    chk("t2_rvalid_t4", rvalid0_v[1], 0);
    chk("t2_busy_t4",   busy_v[1],    0);
    chk("t2_rdata_t4",  rdata_v[1],   32'hDEAD_BEEF);

    // ---- single write from port 1 (instance 1) ----
    do_reset();
    tick();
    req1 = 1'b1; we1 = 1'b1; adr1 = 32'h10; wd1 = 32'h1234;
    #1;
    chk("t3_gnt1", gnt1_v[1], 1);
    chk("t3_gnt0", gnt0_v[1], 0);
    tick();
    req1 = 1'b0;
    #1;
    chk("t3_mem_we_t1", mem_we_v[1],  1);
    chk("t3_adr_t1",    mem_adr_v[1], 32'h10);
    chk("t3_wd_t1",     mem_wd_v[1],  32'h1234);
    chk("t3_busy_t1",   busy_v[1],    1);
    tick();
    chk("t3_mem_we_t2", mem_we_v[1],  0);
    chk("t3_busy_t2",   busy_v[1],    0);
    chk("t3_rvalid_t2", {rvalid1_v[1], rvalid0_v[1]}, 0);
    chk("t3_wd_hold",   mem_wd_v[1],  32'h1234);

    // ---- both ports requesting continuously (instance 1) ----
    do_reset();
    tick();
    req0 = 1'b1; we0 = 1'b0; adr0 = 32'h100;
    req1 = 1'b1; we1 = 1'b0; adr1 = 32'h200;
    for (int k = 0; k < 4; k++) begin
      exp_port = k % 2;
      #1;
      chk("t4_gnt0", gnt0_v[1], (exp_port == 0));
      chk("t4_gnt1", gnt1_v[1], (exp_port == 1));
      a = (exp_port == 1) ? adr1 : adr0;
      tick();
      if (exp_port == 1) adr1 = adr1 + 32'd4;
      else               adr0 = adr0 + 32'd4;
      tick();
      tick();
      chk("t4_rvalid0", rvalid0_v[1], (exp_port == 0));
      chk("t4_rvalid1", rvalid1_v[1], (exp_port == 1));
      chk("t4_rdata",   rdata_v[1],   memf(a));
      tick();
    end

    // ---- lone requester back-to-back, RD_LAT=1 (instance 0) ----
    do_reset();
    tick();
    req0 = 1'b1; we0 = 1'b0; adr0 = 32'h20;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_gnt0_idle", gnt0_v[0], 1);
      a = adr0;
      tick();
      adr0 = adr0 + 32'd4;
      #1;
      chk("t5_gnt0_read", gnt0_v[0], 0);
      tick();
      chk("t5_rvalid0", rvalid0_v[0], 1);
      chk("t5_rdata",   rdata_v[0],   memf(a));
      tick();
    end

    // ---- port 1 arrives while port 0 is reading (instance 1) ----
    do_reset();
    tick();
    req0 = 1'b1; we0 = 1'b0; adr0 = 32'h40;
    #1;
    chk("t6_gnt0", gnt0_v[1], 1);
    tick();
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; adr1 = 32'h300;
    #1;
    chk("t6_gnt1_busy_t1", gnt1_v[1], 0);
    tick();
    adr1 = 32'h304;
    #1;
    chk("t6_gnt1_busy_t2", gnt1_v[1], 0);
    chk("t6_adr_t2",       mem_adr_v[1], 32'h40);
    tick();
    chk("t6_gnt1_resp",   gnt1_v[1],    0);
    chk("t6_rvalid0",     rvalid0_v[1], 1);
    chk("t6_adr_resp",    mem_adr_v[1], 32'h40);
    tick();
    chk("t6_gnt1_idle",   gnt1_v[1], 1);
    tick();
    req1 = 1'b0;
    #1;
    chk("t6_adr_port1",   mem_adr_v[1], 32'h304);
    tick();
    tick();
    chk("t6_rvalid1",     rvalid1_v[1], 1);
    chk("t6_rvalid0_off", rvalid0_v[1], 0);
    chk("t6_rdata1",      rdata_v[1],   memf(32'h304));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
